// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory request/ack port between mem_access_unit and memory
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  localparam int L = DATA_W / 8;

  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [L-1:0]      wbe_n;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, addr, wbe_n, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, addr, wbe_n, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - latency-tolerant MEM stage with lane extraction, ALE detection and flush
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 38
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_load_i,
  input  logic              in_store_i,
  input  logic              in_signed_i,
  input  logic [1:0]        in_size_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_wdata_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  mem_access_unit_if.master dm,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_result_o,
  output logic [TAG_W-1:0]  out_tag_o,
  output logic              out_ale_o,
  output logic              busy_o
);
  localparam int L     = DATA_W / 8;
  localparam int OFS_W = $clog2(L);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic              load_q, load_d;
  logic              signed_q, signed_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [L-1:0]      wbe_n_q, wbe_n_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              ale_q, ale_d;

  logic [1:0]        size_eff;
  logic              misaligned;
  logic              go_mem;
  logic              accept;
  logic [L-1:0]      lane_mask;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] rd_ext;
  logic              rd_sign;
  int                nbits;

  // Dword is reserved on a 32-bit datapath and behaves as a word.
  assign size_eff = (DATA_W == 32 && in_size_i == 2'd3) ? 2'd2 : in_size_i;

  always_comb begin
    misaligned = 1'b0;
    lane_mask  = '1;
    wdata_rep  = in_wdata_i;
    case (size_eff)
      2'd0: begin
        lane_mask = L'(1);
        for (int i = 0; i < L; i++) wdata_rep[8*i +: 8] = in_wdata_i[7:0];
      end
      2'd1: begin
        misaligned = in_addr_i[0];
        lane_mask  = L'(3);
        for (int i = 0; i < L / 2; i++) wdata_rep[16*i +: 16] = in_wdata_i[15:0];
      end
      2'd2: begin
        misaligned = |in_addr_i[1:0];
        lane_mask  = L'(15);
        for (int i = 0; i < L / 4; i++) wdata_rep[32*i +: 32] = in_wdata_i[31:0];
      end
      default: misaligned = |in_addr_i[2:0];
    endcase
  end

  assign go_mem     = (in_load_i | in_store_i) & ~misaligned;
  assign in_ready_o = ~flush_i & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready_i));
  assign accept     = in_valid_i & in_ready_o;

  // Load extraction: move the addressed lanes down, then sign/zero-extend above the access size.
  always_comb begin
    rd_shift = dm.rdata >> {addr_q[OFS_W-1:0], 3'b000};
    nbits    = 8 << size_q;
    case (size_q)
      2'd0:    rd_sign = signed_q & rd_shift[7];
      2'd1:    rd_sign = signed_q & rd_shift[15];
      2'd2:    rd_sign = signed_q & rd_shift[31];
      default: rd_sign = signed_q & rd_shift[DATA_W-1];
    endcase
    for (int i = 0; i < DATA_W; i++) rd_ext[i] = (i < nbits) ? rd_shift[i] : rd_sign;
  end

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    load_d   = load_q;
    signed_d = signed_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wbe_n_d  = wbe_n_q;
    wdata_d  = wdata_q;
    tag_d    = tag_q;
    result_d = result_q;
    ale_d    = ale_q;

    case (state_q)
      S_REQ: begin
        if (flush_i)         state_d = dm.addr_ok ? S_DRAIN : S_IDLE;
        else if (dm.addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dm.data_ok) begin
          state_d  = flush_i ? S_IDLE : S_DONE;
          result_d = load_q ? rd_ext : DATA_W'(addr_q);
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (flush_i || out_ready_i) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (dm.data_ok) state_d = S_IDLE;
      end
      default: ;
    endcase

    // Accepting overrides the DONE->IDLE step so back-to-back ops lose no cycle.
    if (accept) begin
      state_d  = go_mem ? S_REQ : S_DONE;
      wr_d     = in_store_i & go_mem;
      load_d   = in_load_i;
      signed_d = in_signed_i;
      size_d   = size_eff;
      addr_d   = in_addr_i;
      wbe_n_d  = ~(lane_mask << in_addr_i[OFS_W-1:0]);
      wdata_d  = wdata_rep;
      tag_d    = in_tag_i;
      result_d = DATA_W'(in_addr_i);
      ale_d    = (in_load_i | in_store_i) & misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      load_q   <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wbe_n_q  <= '1;
      wdata_q  <= '0;
      tag_q    <= '0;
      result_q <= '0;
      ale_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      load_q   <= load_d;
      signed_q <= signed_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wbe_n_q  <= wbe_n_d;
      wdata_q  <= wdata_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      ale_q    <= ale_d;
    end
  end

  assign dm.req       = (state_q == S_REQ);
  assign dm.wr        = wr_q;
  assign dm.addr      = addr_q;
  assign dm.wbe_n     = wbe_n_q;
  assign dm.wdata     = wdata_q;
  assign out_valid_o  = (state_q == S_DONE);
  assign out_result_o = result_q;
  assign out_tag_o    = tag_q;
  assign out_ale_o    = ale_q;
  assign busy_o       = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed bench for mem_access_unit at DATA_W 32 and 64
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_in_ready, a_load, a_store, a_signed;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, a_result;
  logic [37:0] a_tag, a_tag_o;
  logic        a_out_valid, a_out_ready, a_ale, a_busy;

  logic        b_flush, b_in_valid, b_in_ready, b_load, b_store, b_signed;
  logic [1:0]  b_size;
  logic [31:0] b_addr;
  logic [63:0] b_wdata, b_result;
  logic [37:0] b_tag, b_tag_o;
  logic        b_out_valid, b_out_ready, b_ale, b_busy;

  mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) dma ();
  mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) dmb ();

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TAG_W(38)) dut_a (
    .clk(clk), .resetn(resetn), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .in_load_i(a_load), .in_store_i(a_store), .in_signed_i(a_signed),
    .in_size_i(a_size), .in_addr_i(a_addr), .in_wdata_i(a_wdata), .in_tag_i(a_tag),
    .dm(dma.master),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_result_o(a_result),
    .out_tag_o(a_tag_o), .out_ale_o(a_ale), .busy_o(a_busy)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TAG_W(38)) dut_b (
    .clk(clk), .resetn(resetn), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .in_load_i(b_load), .in_store_i(b_store), .in_signed_i(b_signed),
    .in_size_i(b_size), .in_addr_i(b_addr), .in_wdata_i(b_wdata), .in_tag_i(b_tag),
    .dm(dmb.master),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_result_o(b_result),
    .out_tag_o(b_tag_o), .out_ale_o(b_ale), .busy_o(b_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic a_mem_load(input logic sgn, input logic [1:0] sz, input logic [31:0] ad,
                            input logic [31:0] rd, input logic [3:0] ewbe,
                            input logic [31:0] eres, input logic [37:0] tg);
    a_in_valid = 1'b1; a_load = 1'b1; a_store = 1'b0; a_signed = sgn;
    a_size = sz; a_addr = ad; a_tag = tg;
    step();
    a_in_valid = 1'b0;
    chk("a_req_c1", dma.req, 1);
    chk("a_wbe_n", dma.wbe_n, ewbe);
    chk("a_dm_addr", dma.addr, ad);
    chk("a_dm_wr", dma.wr, 0);
    dma.addr_ok = 1'b1;
    step();
    dma.addr_ok = 1'b0;
    chk("a_req_c2", dma.req, 0);
    chk("a_valid_c2", a_out_valid, 0);
    dma.data_ok = 1'b1; dma.rdata = rd;
    step();
    dma.data_ok = 1'b0;
    chk("a_valid_c3", a_out_valid, 1);
    chk("a_result", a_result, eres);
    chk("a_tag", a_tag_o, tg);
    chk("a_ale", a_ale, 0);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    chk("a_valid_after", a_out_valid, 0);
    chk("a_busy_after", a_busy, 0);
  endtask

  task automatic b_mem_load(input logic sgn, input logic [1:0] sz, input logic [31:0] ad,
                            input logic [63:0] rd, input logic [7:0] ewbe,
                            input logic [63:0] eres);
    b_in_valid = 1'b1; b_load = 1'b1; b_store = 1'b0; b_signed = sgn;
    b_size = sz; b_addr = ad; b_tag = 38'h2A;
    step();
    b_in_valid = 1'b0;
    chk("b_req_c1", dmb.req, 1);
    chk("b_wbe_n", dmb.wbe_n, ewbe);
    dmb.addr_ok = 1'b1;
    step();
    dmb.addr_ok = 1'b0;
    dmb.data_ok = 1'b1; dmb.rdata = rd;
    step();
    dmb.data_ok = 1'b0;
    chk("b_valid_c3", b_out_valid, 1);
    chk("b_result", b_result, eres);
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    chk("b_valid_after", b_out_valid, 0);
  endtask

  initial begin
    int pat[4];
    int idx_in, idx_out, k;
    logic fire_in, fire_out;
    pat = '{1, 0, 1, 1};

    resetn = 1'b0;
    a_flush = 0; a_in_valid = 0; a_load = 0; a_store = 0; a_signed = 0; a_size = 0;
    a_addr = 0; a_wdata = 0; a_tag = 0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_load = 0; b_store = 0; b_signed = 0; b_size = 0;
    b_addr = 0; b_wdata = 0; b_tag = 0; b_out_ready = 0;
    dma.addr_ok = 0; dma.data_ok = 0; dma.rdata = 0;
    dmb.addr_ok = 0; dmb.data_ok = 0; dmb.rdata = 0;
    step();
    step();
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_req", dma.req, 0);
    chk("rst_wr", dma.wr, 0);
    chk("rst_ale", a_ale, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_result", a_result, 0);
    chk("rst_tag", a_tag_o, 0);
    chk("rst_addr", dma.addr, 0);
    chk("rst_wdata", dma.wdata, 0);
    chk("rst_wbe_n", dma.wbe_n, 4'hF);
    chk("rst_wbe_n_b", dmb.wbe_n, 8'hFF);
    chk("rst_in_ready", a_in_ready, 1);
    resetn = 1'b1;
    step();

    // lb signed, top byte lane
    a_mem_load(1'b1, 2'd0, 32'h0000_1003, 32'h80FF_1234, 4'b0111, 32'hFFFF_FF80, 38'h15);

    // sh with addr_ok stalled four cycles
    a_in_valid = 1; a_load = 0; a_store = 1; a_signed = 0; a_size = 2'd1;
    a_addr = 32'h0000_2002; a_wdata = 32'h0000_ABCD; a_tag = 38'h3_0000_0001;
    step();
    a_in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("sh_req", dma.req, 1);
      chk("sh_wr", dma.wr, 1);
      chk("sh_addr", dma.addr, 32'h0000_2002);
      chk("sh_wbe_n", dma.wbe_n, 4'b0011);
      chk("sh_wdata", dma.wdata, 32'hABCD_ABCD);
      if (i == 4) dma.addr_ok = 1'b1;
      step();
    end
    dma.addr_ok = 0;
    chk("sh_req_drop", dma.req, 0);
    dma.data_ok = 1;
    step();
    dma.data_ok = 0;
    chk("sh_valid", a_out_valid, 1);
    chk("sh_result", a_result, 32'h0000_2002);
    chk("sh_tag", a_tag_o, 38'h3_0000_0001);
    a_out_ready = 1;
    step();
    a_out_ready = 0;

    // misaligned lw: ALE, no memory request
    a_in_valid = 1; a_load = 1; a_store = 0; a_size = 2'd2; a_addr = 32'h0000_3001; a_tag = 38'h7;
    step();
    a_in_valid = 0;
    chk("ale_valid_c1", a_out_valid, 1);
    chk("ale_flag", a_ale, 1);
    chk("ale_result", a_result, 32'h0000_3001);
    chk("ale_no_req", dma.req, 0);
    a_out_ready = 1;
    step();
    a_out_ready = 0;
    chk("ale_no_req2", dma.req, 0);
    chk("ale_idle", a_busy, 0);

    // 64-bit datapath: lwu, lw, ld
    b_mem_load(1'b0, 2'd2, 32'h0000_1004, 64'h8765_4321_0000_0000, 8'h0F, 64'h0000_0000_8765_4321);
    b_mem_load(1'b1, 2'd2, 32'h0000_1004, 64'h8765_4321_0000_0000, 8'h0F, 64'hFFFF_FFFF_8765_4321);
    b_mem_load(1'b1, 2'd3, 32'h0000_1008, 64'h8000_0000_0000_0001, 8'h00, 64'h8000_0000_0000_0001);

    // flush while waiting for data, then drain
    a_in_valid = 1; a_load = 1; a_store = 0; a_signed = 0; a_size = 2'd2; a_addr = 32'h0000_4000;
    step();
    a_in_valid = 0;
    dma.addr_ok = 1;
    step();
    dma.addr_ok = 0;
    a_flush = 1;
    step();
    a_flush = 0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_busy", a_busy, 1);
      chk("drain_in_ready", a_in_ready, 0);
      chk("drain_no_valid", a_out_valid, 0);
      if (i == 2) begin
        dma.data_ok = 1; dma.rdata = 32'hDEAD_BEEF;
      end
      step();
    end
    dma.data_ok = 0;
    chk("drain_done_busy", a_busy, 0);
    chk("drain_done_ready", a_in_ready, 1);
    chk("drain_done_valid", a_out_valid, 0);
    a_mem_load(1'b0, 2'd0, 32'h0000_4001, 32'h0000_AB00, 4'b1101, 32'h0000_00AB, 38'h21);

    // pass-through stream with out_ready 1,0,1,1
    a_load = 0; a_store = 0;
    idx_in = 0; idx_out = 0; k = 0;
    for (int cyc = 0; cyc < 20 && idx_out < 4; cyc++) begin
      a_in_valid = (idx_in < 4);
      a_addr = 32'h100 + idx_in;
      a_tag = 38'h11 + 38'(idx_in);
      if (a_out_valid) begin
        a_out_ready = (k < 4) ? pat[k][0] : 1'b1;
        k++;
      end else begin
        a_out_ready = 1'b1;
      end
      #1;
      fire_in  = a_in_valid & a_in_ready;
      fire_out = a_out_valid & a_out_ready;
      if (fire_out) begin
        chk("pt_tag", a_tag_o, 38'h11 + 38'(idx_out));
        chk("pt_result", a_result, 32'h100 + idx_out);
        idx_out++;
      end
      if (fire_in) idx_in++;
      step();
    end
    a_in_valid = 0;
    chk("pt_delivered", 64'(idx_out), 64'd4);
    chk("pt_cycles_k", 64'(k), 64'd5);
    step();
    chk("pt_no_dup", a_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
